tm1638_key_reader: RTL and testbench

- Reads the 8 front-panel keys of the TM1638 LED&KEY module over its 3-wire serial link (STB/CLK/DIO).
- Complements the display path that writes counter digits to the same module. It initiates the read-key command (0x42), then receives 4 scan bytes.
- Publishes a debounced-by-polling key vector plus per-key press pulses to the counter control logic, e.g. as replacements for sw0/sw1/sw2.

---
 rtl/tm1638_key_reader.sv | 229 ++++++++++++++++++++++
 tb/tb_tm1638_key_reader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: issues the read-key command (0x42) over STB/CLK/DIO,
// shifts in the four scan bytes and publishes the 8-key vector with press pulses.
module tm1638_key_reader #(
    parameter int CLK_DIV     = 50,
    parameter int POLL_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tm_dio_in,
    output logic       tm_stb,
    output logic       tm_clk,
    output logic       tm_dio_out,
    output logic       tm_dio_oe,
    output logic [7:0] keys,
    output logic [7:0] key_press,
    output logic       key_valid,
    output logic       busy
);

    localparam int DIV_W  = $clog2(2 * CLK_DIV);
    localparam int POLL_W = $clog2(POLL_CYCLES + 1);
    localparam logic [DIV_W-1:0]  HALF_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  BIT_LAST  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
    localparam logic [7:0]        CMD_READ_KEYS = 8'h42;

    typedef enum logic [2:0] {
        IDLE,
        START,
        CMD,
        WAIT,
        READ,
        STOP,
        DONE
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_divCnt;
    logic [4:0]          r_bitCnt;
    logic [POLL_W-1:0]   r_pollCnt;
    logic                r_dioMeta;
    logic                r_dioSync;
    logic [31:0]         r_shift;
    logic [7:0]          r_keys;
    logic [7:0]          r_keyPress;
    logic                r_keyValid;
    logic                r_tmStb;
    logic                r_tmClk;
    logic                r_tmDioOut;
    logic                r_tmDioOe;
    logic                r_busy;

    state_t              w_nextState;
    logic [DIV_W-1:0]    w_nextDiv;
    logic [4:0]          w_nextBit;
    logic                w_nextStb;
    logic                w_nextClk;
    logic                w_nextDioOut;
    logic                w_nextOe;
    logic                w_nextBusy;
    logic [7:0]          w_newKeys;

    // Key k sits in bit 0 (S1..S4) or bit 4 (S5..S8) of scan byte k mod 4.
    assign w_newKeys = {r_shift[28], r_shift[20], r_shift[12], r_shift[4],
                        r_shift[24], r_shift[16], r_shift[8],  r_shift[0]};

    // Pin values are decoded from the next state and registered, so the
    // TM1638 lines never glitch while staying aligned with r_state.
    always_comb begin
        w_nextState  = r_state;
        w_nextDiv    = r_divCnt + 1'b1;
        w_nextBit    = r_bitCnt;
        w_nextStb    = 1'b1;
        w_nextClk    = 1'b1;
        w_nextDioOut = 1'b0;
        w_nextOe     = 1'b0;
        w_nextBusy   = 1'b0;

        case (r_state)
            IDLE: begin
                w_nextDiv = '0;
                if (r_pollCnt == POLL_LAST) begin
                    w_nextState = START;
                end
            end
            START: begin
                if (r_divCnt == HALF_LAST) begin
                    w_nextState = CMD;
                    w_nextDiv   = '0;
                    w_nextBit   = '0;
                end
            end
            CMD: begin
                if (r_divCnt == BIT_LAST) begin
                    w_nextDiv = '0;
                    if (r_bitCnt == 5'd7) begin
                        w_nextState = WAIT;
                        w_nextBit   = '0;
                    end else begin
                        w_nextBit = r_bitCnt + 5'd1;
                    end
                end
            end
            WAIT: begin
                if (r_divCnt == BIT_LAST) begin
                    w_nextState = READ;
                    w_nextDiv   = '0;
                    w_nextBit   = '0;
                end
            end
            READ: begin
                if (r_divCnt == BIT_LAST) begin
                    w_nextDiv = '0;
                    if (r_bitCnt == 5'd31) begin
                        w_nextState = STOP;
                        w_nextBit   = '0;
                    end else begin
                        w_nextBit = r_bitCnt + 5'd1;
                    end
                end
            end
            STOP: begin
                if (r_divCnt == HALF_LAST) begin
                    w_nextState = DONE;
                    w_nextDiv   = '0;
                end
            end
            DONE: begin
                w_nextState = IDLE;
                w_nextDiv   = '0;
            end
            default: begin
                w_nextState = IDLE;
                w_nextDiv   = '0;
                w_nextBit   = '0;
            end
        endcase

        case (w_nextState)
            START: begin
                w_nextStb  = 1'b0;
                w_nextOe   = 1'b1;
                w_nextBusy = 1'b1;
            end
            CMD: begin
                w_nextStb    = 1'b0;
                w_nextOe     = 1'b1;
                w_nextBusy   = 1'b1;
                w_nextClk    = (w_nextDiv > HALF_LAST);
                w_nextDioOut = CMD_READ_KEYS[w_nextBit[2:0]];
            end
            READ: begin
                w_nextStb  = 1'b0;
                w_nextBusy = 1'b1;
                w_nextClk  = (w_nextDiv > HALF_LAST);
            end
            WAIT, STOP: begin
                w_nextStb  = 1'b0;
                w_nextBusy = 1'b1;
            end
            default: begin
                w_nextStb = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_divCnt   <= '0;
            r_bitCnt   <= '0;
            r_pollCnt  <= '0;
            r_tmStb    <= 1'b1;
            r_tmClk    <= 1'b1;
            r_tmDioOut <= 1'b0;
            r_tmDioOe  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_divCnt   <= w_nextDiv;
            r_bitCnt   <= w_nextBit;
            r_tmStb    <= w_nextStb;
            r_tmClk    <= w_nextClk;
            r_tmDioOut <= w_nextDioOut;
            r_tmDioOe  <= w_nextOe;
            r_busy     <= w_nextBusy;
            if (r_state != IDLE) begin
                r_pollCnt <= '0;
            end else if (r_pollCnt != POLL_LAST) begin
                r_pollCnt <= r_pollCnt + 1'b1;
            end
        end
    end

    // DIO is sampled on the last low-phase cycle, just before tm_clk rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dioMeta  <= 1'b0;
            r_dioSync  <= 1'b0;
            r_shift    <= '0;
            r_keys     <= '0;
            r_keyPress <= '0;
            r_keyValid <= 1'b0;
        end else begin
            r_dioMeta  <= tm_dio_in;
            r_dioSync  <= r_dioMeta;
            r_keyPress <= '0;
            r_keyValid <= 1'b0;
            if (r_state == READ && r_divCnt == HALF_LAST) begin
                r_shift <= {r_dioSync, r_shift[31:1]};
            end
            if (w_nextState == DONE) begin
                r_keys     <= w_newKeys;
                r_keyPress <= w_newKeys & ~r_keys;
                r_keyValid <= 1'b1;
            end
        end
    end

    assign tm_stb     = r_tmStb;
    assign tm_clk     = r_tmClk;
    assign tm_dio_out = r_tmDioOut;
    assign tm_dio_oe  = r_tmDioOe;
    assign busy       = r_busy;
    assign keys       = r_keys;
    assign key_press  = r_keyPress;
    assign key_valid  = r_keyValid;

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Directed bench for tm1638_key_reader with a TM1638 bus model that captures
// the command byte and serves scan bytes on the falling edge of tm_clk.
module tb_tm1638_key_reader;

    logic       clk;
    logic       rst;
    logic       tm_dio_in;
    logic       tm_stb;
    logic       tm_clk;
    logic       tm_dio_out;
    logic       tm_dio_oe;
    logic [7:0] keys;
    logic [7:0] key_press;
    logic       key_valid;
    logic       busy;

    int          totalCount;
    int          badCount;
    logic [31:0] rdBits;
    logic [7:0]  cmdBits;
    int          cmdCnt;
    int          rdIdx;

    tm1638_key_reader #(
        .CLK_DIV    (4),
        .POLL_CYCLES(100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tm_dio_in (tm_dio_in),
        .tm_stb    (tm_stb),
        .tm_clk    (tm_clk),
        .tm_dio_out(tm_dio_out),
        .tm_dio_oe (tm_dio_oe),
        .keys      (keys),
        .key_press (key_press),
        .key_valid (key_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One strobe-low frame of the TM1638: command bits in on rising tm_clk,
    // scan bits out on falling tm_clk once the controller releases DIO.
    always begin
        @(negedge tm_stb);
        rdIdx   = 0;
        cmdCnt  = 0;
        cmdBits = 8'h00;
        while (tm_stb == 1'b0) begin
            @(tm_clk or tm_stb);
            if (tm_stb == 1'b0) begin
                if (tm_clk && tm_dio_oe && cmdCnt < 8) begin
                    cmdBits[cmdCnt] = tm_dio_out;
                    cmdCnt++;
                end else if (!tm_clk && !tm_dio_oe && rdIdx < 32) begin
                    tm_dio_in = rdBits[rdIdx];
                    rdIdx++;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // bytesIn is {byte3, byte2, byte1, byte0}; offsets count from the first START cycle.
    task automatic applyStimulus(input string tag, input logic [31:0] bytesIn,
                                 input int expWait, input logic [7:0] expKeys,
                                 input logic [7:0] expPress);
        int waited;
        int oeBad;
        int frameBad;
        rdBits = bytesIn;
        waited = 0;
        while (tm_stb && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_gap"}, 32'(waited), 32'(expWait));
        if (tm_stb) begin
            return;
        end
        oeBad    = 0;
        frameBad = 0;
        for (int i = 1; i <= 336; i++) begin
            @(negedge clk);
            if (i >= 68 && i <= 331 && tm_dio_oe) begin
                oeBad++;
            end
            if (i < 336 && (key_valid || tm_stb || !busy)) begin
                frameBad++;
            end
        end
        checkOutput({tag, "_valid"}, 32'(key_valid), 32'd1);
        checkOutput({tag, "_keys"}, 32'(keys), 32'(expKeys));
        checkOutput({tag, "_press"}, 32'(key_press), 32'(expPress));
        checkOutput({tag, "_stb_busy"}, {30'd0, tm_stb, busy}, 32'h2);
        checkOutput({tag, "_oe_read"}, 32'(oeBad), 32'd0);
        checkOutput({tag, "_frame"}, 32'(frameBad), 32'd0);
        checkOutput({tag, "_cmd"}, {24'd0, cmdBits}, 32'h42);
        checkOutput({tag, "_cmdcnt"}, 32'(cmdCnt), 32'd8);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, {23'd0, key_valid, key_press}, 32'h0);
        checkOutput({tag, "_hold"}, 32'(keys), 32'(expKeys));
    endtask

    initial begin
        totalCount = 0;
        badCount   = 0;
        rst        = 1'b1;
        tm_dio_in  = 1'b0;
        rdBits     = 32'h11001001;
        repeat (5) @(negedge clk);
        checkOutput("reset_pins", {28'd0, tm_stb, tm_clk, tm_dio_oe, tm_dio_out}, 32'hC);
        checkOutput("reset_keys", {15'd0, keys, key_press, key_valid, busy}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            checkOutput("idle_hold", {21'd0, tm_stb, tm_clk, tm_dio_oe, keys}, 32'h600);
            @(negedge clk);
        end
        checkOutput("stb_fall", 32'(tm_stb), 32'd0);

        applyStimulus("decode", 32'h11001001, 0, 8'hA9, 8'hA9);
        applyStimulus("press", 32'h11011001, 100, 8'hAD, 8'h04);
        applyStimulus("repeat", 32'h11011001, 100, 8'hAD, 8'h00);
        applyStimulus("release", 32'h00000000, 100, 8'h00, 8'h00);

        rdBits = 32'hFFFFFFFF;
        begin
            int waited;
            waited = 0;
            while (tm_stb && waited < 1000) begin
                @(negedge clk);
                waited++;
            end
            checkOutput("midrd_gap", 32'(waited), 32'd100);
        end
        repeat (158) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrd_pins", {28'd0, tm_stb, tm_clk, tm_dio_oe, busy}, 32'hC);
        checkOutput("midrd_keys", 32'(keys), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        applyStimulus("after_rst", 32'h11011001, 100, 8'hAD, 8'hAD);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
